// File: rtl/keypad_pkg.sv
// Shared constants and event payload for the keypad matrix scanner.
package keypad_pkg;

   localparam int unsigned KEY_ROWS  = 4;
   localparam int unsigned KEY_COLS  = 4;
   localparam int unsigned KEY_COUNT = 16;
   localparam int unsigned KEY_IDX_W = 4;

   // One press/release event as queued for game logic.
   typedef struct packed {
      logic                 press;
      logic [KEY_IDX_W-1:0] code;
   } key_event_t;

   // Matrix positions of the game keys.
   localparam logic [KEY_IDX_W-1:0] KEY_LEFT  = 4'd4;
   localparam logic [KEY_IDX_W-1:0] KEY_FIRE  = 4'd5;
   localparam logic [KEY_IDX_W-1:0] KEY_RIGHT = 4'd6;

endpackage

// File: rtl/keypad_matrix_scanner_fifo.sv
// Synchronous event FIFO with registered head, empty and full flags.
module key_event_fifo
   import keypad_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  key_event_t din,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output key_event_t head
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   key_event_t    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
   logic [CW-1:0] count, count_next;
   logic          do_push, do_pop;
   key_event_t    head_next;

   // Next-state pointers/count; head comes from the bypass when the pushed entry becomes the head.
   always_comb begin
      do_pop      = pop && !empty;
      do_push     = push && (!full || do_pop);
      rd_ptr_next = rd_ptr + (do_pop  ? AW'(1) : AW'(0));
      wr_ptr_next = wr_ptr + (do_push ? AW'(1) : AW'(0));
      count_next  = count + CW'(do_push) - CW'(do_pop);
      if (count_next == '0)
         head_next = '0;
      else if (do_push && ((count - CW'(do_pop)) == '0))
         head_next = din;
      else
         head_next = mem[rd_ptr_next];
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers, occupancy and registered head/flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         head   <= '0;
      end else begin
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
         count  <= count_next;
         empty  <= (count_next == '0);
         full   <= (count_next == CW'(FIFO_DEPTH));
         head   <= head_next;
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column strobe, frame debounce, event queue.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 16,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  col_out,
   input  logic [3:0]  row_in,
   output logic        key_valid,
   input  logic        key_ready,
   output logic [3:0]  key_code,
   output logic        key_press,
   output logic [15:0] key_state,
   output logic        overflow,
   input  logic        ovf_clr
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_FRAMES);

   logic [3:0]           row_meta, row_sync;
   logic                 scan_on;
   logic [DW-1:0]        dwell_cnt;
   logic [1:0]           col_idx;
   logic [KEY_COUNT-1:0] raw_next, raw_prev, frame, pending, pending_next;
   logic [SW-1:0]        stab_cnt, stab_next;
   logic                 upd_req;
   logic                 sample, commit;
   logic [3:0]           bit_idx;
   logic                 ev_valid, push_ok, drop;
   logic [3:0]           ev_idx;
   key_event_t           ev, head;
   logic                 fifo_full, fifo_empty, fifo_pop;

   // Two-flop synchroniser on the row returns (idle rows read high).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Column strobe: one-cold rotation, SCAN_DIV cycles per column.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_on   <= 1'b0;
         dwell_cnt <= '0;
         col_idx   <= '0;
         col_out   <= 4'b1111;
      end else if (!scan_on) begin
         scan_on <= 1'b1;
         col_out <= 4'b1110;
      end else if (dwell_cnt == DWELL_LAST) begin
         dwell_cnt <= '0;
         col_idx   <= col_idx + 2'd1;
         col_out   <= {col_out[2:0], col_out[3]};
      end else begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

   // Frame assembly, debounce count and lowest-index event selection.
   always_comb begin
      sample  = scan_on && (dwell_cnt == DWELL_LAST);
      commit  = sample && (col_idx == 2'd3);
      frame   = raw_next;
      bit_idx = '0;
      for (int r = 0; r < int'(KEY_ROWS); r++) begin
         bit_idx        = 4'(r * int'(KEY_COLS)) + {2'b00, col_idx};
         frame[bit_idx] = ~row_sync[2'(r)];
      end
      if (frame != raw_prev)
         stab_next = SW'(1);
      else if (stab_cnt == STAB_MAX)
         stab_next = stab_cnt;
      else
         stab_next = stab_cnt + SW'(1);

      ev_valid = |pending;
      ev_idx   = '0;
      for (int i = int'(KEY_COUNT) - 1; i >= 0; i--) begin
         if (pending[4'(i)]) ev_idx = 4'(i);
      end
      ev.code  = ev_idx;
      ev.press = key_state[ev_idx];

      fifo_pop = key_ready && !fifo_empty;
      push_ok  = ev_valid && (!fifo_full || fifo_pop);
      drop     = ev_valid && !push_ok;

      pending_next = pending;
      if (ev_valid) pending_next[ev_idx] = 1'b0;
      if (upd_req)  pending_next = pending_next | (raw_prev ^ key_state);
   end

   // Raw sampling, frame commit and debounced state update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         raw_next  <= '0;
         raw_prev  <= '0;
         stab_cnt  <= '0;
         upd_req   <= 1'b0;
         key_state <= '0;
         pending   <= '0;
      end else begin
         if (sample) raw_next <= frame;
         if (commit) begin
            raw_prev <= frame;
            stab_cnt <= stab_next;
            upd_req  <= (stab_next == STAB_MAX) && (frame != key_state);
         end else begin
            upd_req  <= 1'b0;
         end
         if (upd_req) key_state <= raw_prev;
         pending <= pending_next;
      end
   end

   // Sticky drop flag; a drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   key_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .din   (ev),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   assign key_valid = !fifo_empty;
   assign key_code  = head.code;
   assign key_press = head.press;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed self-checking bench for keypad_matrix_scanner (SCAN_DIV=8, DEBOUNCE=3, FIFO=4).
module tb_keypad_matrix_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  col_out;
   logic [3:0]  row_in;
   logic        key_valid;
   logic        key_ready;
   logic [3:0]  key_code;
   logic        key_press;
   logic [15:0] key_state;
   logic        overflow;
   logic        ovf_clr;

   logic [15:0] keys;
   int unsigned cyc;
   int          n_checks = 0;
   int          n_fail   = 0;

   keypad_matrix_scanner #(
      .SCAN_DIV        (8),
      .DEBOUNCE_FRAMES (3),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .col_out   (col_out),
      .row_in    (row_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_code  (key_code),
      .key_press (key_press),
      .key_state (key_state),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   // Passive matrix: a row reads low when a held key sits on a driven column.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_out[2'(c)] && keys[4'(r * 4 + c)]) row_in[2'(r)] = 1'b0;
   end

   // Clock edges since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int unsigned n);
      int guard = 0;
      while (cyc < n) begin
         @(negedge clk);
         guard++;
         if (guard > 20000) begin
            n_fail++;
            $display("FAIL wait_cyc timeout: cyc %0d target %0d", cyc, n);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "timeout");
         end
      end
   endtask

   initial begin
      logic [3:0] one_hot;
      logic [3:0] exp_col;
      int col_bad;
      int state_bad;
      logic seen_valid;

      reset = 1'b0; keys = '0; key_ready = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_col_out",   32'(col_out),   32'hF);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_code",  32'(key_code),  32'h0);
      chk("rst_key_press", 32'(key_press), 32'h0);
      chk("rst_key_state", 32'(key_state), 32'h0);
      chk("rst_overflow",  32'(overflow),  32'h0);
      reset = 1'b1;

      // Idle scan for 10 frames.
      col_bad = 0; state_bad = 0; seen_valid = 1'b0;
      for (int k = 1; k <= 320; k++) begin
         wait_cyc(k);
         one_hot = 4'b0001 << (((k - 1) / 8) % 4);
         exp_col = ~one_hot;
         if (col_out !== exp_col) col_bad++;
         if (key_state !== 16'h0) state_bad++;
         seen_valid = seen_valid | key_valid;
         if (k == 1)  chk("col_first", 32'(col_out), 32'hE);
         if (k == 8)  chk("col_dwell_end", 32'(col_out), 32'hE);
         if (k == 9)  chk("col1", 32'(col_out), 32'hD);
         if (k == 17) chk("col2", 32'(col_out), 32'hB);
         if (k == 25) chk("col3", 32'(col_out), 32'h7);
         if (k == 33) chk("col_wrap", 32'(col_out), 32'hE);
      end
      chk("idle_col_seq",   32'(col_bad),    32'h0);
      chk("idle_state",     32'(state_bad),  32'h0);
      chk("idle_no_valid",  32'(seen_valid), 32'h0);

      // Clean press of key 5.
      wait_cyc(321); keys[5] = 1'b1;
      wait_cyc(417); chk("k5_state_pre", 32'(key_state), 32'h0);
      wait_cyc(418); chk("k5_state",     32'(key_state), 32'h0020);
                     chk("k5_valid_pre", 32'(key_valid), 32'h0);
      wait_cyc(419); chk("k5_valid",     32'(key_valid), 32'h1);
                     chk("k5_code",      32'(key_code),  32'h5);
                     chk("k5_press",     32'(key_press), 32'h1);
      key_ready = 1'b1;
      wait_cyc(420); chk("k5_popped",    32'(key_valid), 32'h0);

      // Release key 5.
      wait_cyc(481); keys[5] = 1'b0;
      wait_cyc(579); chk("k5r_valid", 32'(key_valid), 32'h1);
                     chk("k5r_code",  32'(key_code),  32'h5);
                     chk("k5r_press", 32'(key_press), 32'h0);
                     chk("k5r_state", 32'(key_state), 32'h0);
      wait_cyc(580); chk("k5r_popped", 32'(key_valid), 32'h0);

      // Bounce on alternate frames: no event, no state change.
      state_bad = 0; seen_valid = 1'b0;
      for (int k = 609; k <= 960; k++) begin
         wait_cyc(k);
         if ((k - 609) % 32 == 0)
            keys[5] = ((k - 609) / 32 < 8) && ((((k - 609) / 32) % 2) == 0);
         if (key_state !== 16'h0) state_bad++;
         seen_valid = seen_valid | key_valid;
      end
      chk("bounce_state",    32'(state_bad),  32'h0);
      chk("bounce_no_valid", 32'(seen_valid), 32'h0);

      // Keys 0, 6, 15 together: ordered press events.
      wait_cyc(961); keys = 16'h8041;
      wait_cyc(1058); chk("multi_state", 32'(key_state), 32'h8041);
      wait_cyc(1059); chk("multi_ev0_valid", 32'(key_valid), 32'h1);
                      chk("multi_ev0_code",  32'(key_code),  32'h0);
                      chk("multi_ev0_press", 32'(key_press), 32'h1);
      wait_cyc(1060); chk("multi_ev1_code",  32'(key_code),  32'h6);
      wait_cyc(1061); chk("multi_ev2_code",  32'(key_code),  32'hF);
                      chk("multi_ev2_press", 32'(key_press), 32'h1);
      wait_cyc(1062); chk("multi_drained",   32'(key_valid), 32'h0);

      // Release all three.
      wait_cyc(1089); keys = 16'h0000;
      wait_cyc(1186); chk("multi_rel_state", 32'(key_state), 32'h0);
      wait_cyc(1187); chk("multi_rel_code",  32'(key_code),  32'h0);
                      chk("multi_rel_press", 32'(key_press), 32'h0);

      // Five presses with consumer stalled: FIFO fills, code 4 dropped.
      wait_cyc(1217); key_ready = 1'b0; keys = 16'h001F;
      wait_cyc(1314); chk("ovf_state", 32'(key_state), 32'h001F);
      wait_cyc(1318); chk("ovf_pre",       32'(overflow), 32'h0);
                      chk("ovf_head_code", 32'(key_code), 32'h0);
      wait_cyc(1319); chk("ovf_set",       32'(overflow), 32'h1);
      wait_cyc(1325); chk("ovf_head_hold", 32'(key_code), 32'h0);
                      chk("ovf_head_valid", 32'(key_valid), 32'h1);
      key_ready = 1'b1;
      wait_cyc(1326); chk("ovf_pop_code",  32'(key_code), 32'h1);
                      chk("ovf_still_set", 32'(overflow), 32'h1);
      key_ready = 1'b0; ovf_clr = 1'b1;
      wait_cyc(1327); chk("ovf_cleared",   32'(overflow), 32'h0);
      ovf_clr = 1'b0; key_ready = 1'b1;
      wait_cyc(1328); chk("ovf_pop2_code", 32'(key_code), 32'h2);
      key_ready = 1'b0;

      // Mid-dwell reset with two events queued.
      wait_cyc(1330);
      chk("pre_rst_valid", 32'(key_valid), 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(key_valid), 32'h0);
      chk("mid_rst_col",   32'(col_out),   32'hF);
      chk("mid_rst_state", 32'(key_state), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1; key_ready = 1'b1;
      wait_cyc(1);  chk("rerun_col_first", 32'(col_out),   32'hE);
                    chk("rerun_valid",     32'(key_valid), 32'h0);
      wait_cyc(97); chk("rerun_state_pre", 32'(key_state), 32'h0);
      wait_cyc(98); chk("rerun_state",     32'(key_state), 32'h001F);
      wait_cyc(99); chk("rerun_ev0_code",  32'(key_code),  32'h0);
                    chk("rerun_ev0_press", 32'(key_press), 32'h1);
      wait_cyc(103); chk("rerun_ev4_code", 32'(key_code),  32'h4);
                     chk("rerun_ev4_valid", 32'(key_valid), 32'h1);
      wait_cyc(104); chk("rerun_drained",  32'(key_valid), 32'h0);
                     chk("rerun_no_ovf",   32'(overflow),  32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart of the LED matrix scan driver: strobes the columns of a 4x4 active-low push-button matrix and samples the rows.
- Debounces whole-matrix snapshots and converts stable changes into press/release events.
- Events drain through a small FIFO with a valid/ready handshake to game logic, replacing raw left/right/fire pin reads.

Parameters:
- SCAN_DIV, 16, clk cycles each column is driven (dwell); legal range >= 8.
- DEBOUNCE_FRAMES, 4, consecutive identical full-matrix frames required before the stable state updates; legal range >= 1.
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- col_out  output  4  column strobes, active-low, one-cold
- row_in  input  4  row returns, active-low (0 = pressed key on driven column)
- key_valid  output  1  event available
- key_ready  input  1  consumer accepts event
- key_code  output  4  key index = row*4 + col
- key_press  output  1  1 = press, 0 = release
- key_state  output  16  debounced level per key, 1 = held
- overflow  output  1  sticky: an event was dropped
- ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (reset = 0, async):
  - col_out = 4'b1111; key_valid = 0; key_code = 0; key_press = 0; key_state = 0; overflow = 0.
  - FIFO emptied; dwell counter, column index, debounce count and raw registers all cleared.
  - Asserting reset mid-scan or with a non-empty FIFO discards everything.
- Synchroniser: row_in passes through a 2-flop synchroniser before any use.
- Scan:
  - First cycle after reset release: col_out = 4'b1110 (column 0). Columns advance 0,1,2,3,0 every SCAN_DIV cycles.
  - Exactly one column is low at any time after reset.
- Sampling:
  - On the last dwell cycle of column c, synchronised ~row_in[r] is written to raw_next[r*4+c].
  - One frame = 4*SCAN_DIV cycles. Frame commit happens on the last dwell cycle of column 3.
- Debounce, at each frame commit:
  - If raw_next == raw_prev, stab_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stab_cnt = 1.
  - raw_prev <= raw_next.
  - When stab_cnt reaches DEBOUNCE_FRAMES and raw_next != key_state, then on the next cycle key_state <= raw_next and pending |= raw_next ^ key_state.
  - A change anywhere in the matrix restarts the count for the whole matrix.
- Event emission:
  - While pending != 0, one event per cycle, lowest index first: code = index, press = key_state[index]. That pending bit is cleared.
  - At most 16 events per frame; SCAN_DIV >= 8 guarantees drain before the next commit.
- FIFO push rules:
  - FIFO not full: push.
  - FIFO full: event dropped, overflow <= 1 the same cycle.
  - Pop and push in the same cycle on a full FIFO: push succeeds.
- overflow: ovf_clr = 1 clears it. If a drop occurs in the same cycle as ovf_clr, overflow stays set.
- Output handshake:
  - key_valid = FIFO non-empty; key_code/key_press show the head entry.
  - Pop when key_valid && key_ready.
  - Outputs are registered; first event of a burst appears 1 cycle after its push.
  - Head must hold stable while key_valid && !key_ready.
  - key_ready with an empty FIFO: no effect.
- Latency for a clean press seen first in committed frame f:
  - key_state updates 1 cycle after commit of frame f+DEBOUNCE_FRAMES-1.
  - Event pushed 1 cycle later; key_valid 1 cycle after that.
- Bounce shorter than DEBOUNCE_FRAMES frames produces no event and no key_state change.

Decomposition:
- Package keypad_pkg holds:
  - KEY_ROWS = 4, KEY_COLS = 4, KEY_COUNT = 16.
  - Typedef key_event_t {press: 1 bit, code: 4 bits}.
  - Key index constants: KEY_LEFT = 4, KEY_RIGHT = 6, KEY_FIRE = 5.
- Sub-module key_event_fifo: synchronous FIFO of key_event_t.
  - Parameter FIFO_DEPTH; push/full/pop/empty; registered head output.
  - Overflow logic stays in the parent.

Test Plan (bench uses SCAN_DIV=8, DEBOUNCE_FRAMES=3, FIFO_DEPTH=4; frame = 32 cycles):
- Reset release, no keys -> col_out cycles 1110,1101,1011,0111 every 8 cycles; key_valid stays 0 and key_state = 0 for 10 frames.
- Key 5 (row1/col1) held clean from frame 0 -> after 3 commits, key_state = 16'h0020; one event {press=1, code=5}. Release after 5 frames -> {press=0, code=5}; key_state = 0.
- Key 5 bounces on/off every alternate frame for 8 frames -> no event; key_state stays 0.
- Keys 0, 6 and 15 pressed in the same frame, key_ready = 1 -> three consecutive press events in code order 0, 6, 15; key_state = 16'h8041.
- key_ready = 0 with five simultaneous presses (codes 0-4) -> FIFO holds 0-3, code 4 dropped, overflow = 1. Head holds code 0 until ready. ovf_clr -> overflow = 0.
- Reset asserted mid-dwell with 2 events queued -> key_valid = 0 and col_out = 1111 immediately. After release, keys still held produce fresh press events once debounced.
